// File: rtl/avst_word_rx.sv
// Byte-wide Avalon-ST receiver that packs fixed-length MSB-first packets into one word,
// holds the word on a valid/ready port, and flags and counts packets of the wrong length.
module avst_word_rx #(
  parameter int WORD_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              data_in,
  input  logic                    end_in,
  input  logic                    valid_in,
  output logic                    ready_in,
  output logic [8*WORD_BYTES-1:0] word_out,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    len_err,
  output logic [15:0]             pkt_count,
  output logic [15:0]             err_count
);

  localparam int W  = 8 * WORD_BYTES;
  localparam int CW = $clog2(WORD_BYTES);
  localparam logic [CW-1:0] LAST_IDX = CW'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  word_q, word_d;
  logic          wordValid_q, wordValid_d;
  logic          ready_q, ready_d;
  logic          lenErr_q, lenErr_d;
  logic [15:0]   pktCount_q, pktCount_d;
  logic [15:0]   errCount_q, errCount_d;

  logic          beat;
  logic [W-1:0]  accShifted;
  logic [15:0]   pktCountInc;
  logic [15:0]   errCountInc;

  assign beat        = valid_in && ready_q;
  assign accShifted  = {acc_q[W-9:0], data_in};
  assign pktCountInc = (pktCount_q == 16'hFFFF) ? pktCount_q : pktCount_q + 16'd1;
  assign errCountInc = (errCount_q == 16'hFFFF) ? errCount_q : errCount_q + 16'd1;

  // Synchronous reset drops any partial packet or held word without counting it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      acc_q       <= '0;
      word_q      <= '0;
      wordValid_q <= 1'b0;
      ready_q     <= 1'b1;
      lenErr_q    <= 1'b0;
      pktCount_q  <= '0;
      errCount_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      word_q      <= word_d;
      wordValid_q <= wordValid_d;
      ready_q     <= ready_d;
      lenErr_q    <= lenErr_d;
      pktCount_q  <= pktCount_d;
      errCount_q  <= errCount_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    word_d      = word_q;
    wordValid_d = wordValid_q;
    ready_d     = ready_q;
    lenErr_d    = 1'b0;
    pktCount_d  = pktCount_q;
    errCount_d  = errCount_q;

    unique case (state_q)
      COLLECT: begin
        if (beat) begin
          acc_d = accShifted;
          if (end_in) begin
            cnt_d = '0;
            if (cnt_q == LAST_IDX) begin
              word_d      = accShifted;
              wordValid_d = 1'b1;
              ready_d     = 1'b0;
              state_d     = HOLD;
            end else begin
              lenErr_d   = 1'b1;
              errCount_d = errCountInc;
            end
          end else if (cnt_q == LAST_IDX) begin
            // Full word seen with no end marker: swallow the rest of the packet.
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      DRAIN: begin
        if (beat && end_in) begin
          lenErr_d   = 1'b1;
          errCount_d = errCountInc;
          state_d    = COLLECT;
        end
      end

      HOLD: begin
        if (word_ready) begin
          wordValid_d = 1'b0;
          ready_d     = 1'b1;
          pktCount_d  = pktCountInc;
          state_d     = COLLECT;
        end
      end

      default: begin
        state_d = COLLECT;
        cnt_d   = '0;
        ready_d = 1'b1;
      end
    endcase
  end

  assign ready_in   = ready_q;
  assign word_out   = word_q;
  assign word_valid = wordValid_q;
  assign len_err    = lenErr_q;
  assign pkt_count  = pktCount_q;
  assign err_count  = errCount_q;

endmodule

// File: tb/tb_avst_word_rx.sv
// Directed and scoreboarded bench for avst_word_rx with 4-byte words; inputs change
// just after the rising edge or on the falling edge, outputs are sampled on the falling edge.
module tb_avst_word_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  dataIn = '0;
  logic        endIn = 1'b0;
  logic        validIn = 1'b0;
  logic        readyIn;
  logic [31:0] wordOut;
  logic        wordValid;
  logic        wordReady = 1'b1;
  logic        lenErr;
  logic [15:0] pktCount;
  logic [15:0] errCount;

  int checks = 0;
  int failures = 0;

  logic [31:0] expQ[$];

  avst_word_rx #(.WORD_BYTES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (dataIn),
    .end_in     (endIn),
    .valid_in   (validIn),
    .ready_in   (readyIn),
    .word_out   (wordOut),
    .word_valid (wordValid),
    .word_ready (wordReady),
    .len_err    (lenErr),
    .pkt_count  (pktCount),
    .err_count  (errCount)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Offers one byte and returns just after the edge that accepts it.
  task automatic applyStimulus(input logic [7:0] d, input logic e);
    int guard;
    guard = 0;
    @(negedge clk);
    dataIn  = d;
    endIn   = e;
    validIn = 1'b1;
    while (!readyIn && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) checkOutput("beat_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    validIn = 1'b0;
    endIn   = 1'b0;
  endtask

  task automatic sendPacket(input logic [31:0] w);
    applyStimulus(w[31:24], 1'b0);
    applyStimulus(w[23:16], 1'b0);
    applyStimulus(w[15:8],  1'b0);
    applyStimulus(w[7:0],   1'b1);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset   = 1'b1;
    validIn = 1'b0;
    endIn   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int got;
    int budget;
    logic [31:0] w;
    logic [31:0] exp;

    doReset();
    checkOutput("rst_ready", readyIn, 1);
    checkOutput("rst_valid", wordValid, 0);
    checkOutput("rst_word", wordOut, 0);
    checkOutput("rst_lenerr", lenErr, 0);
    checkOutput("rst_pkt", pktCount, 0);
    checkOutput("rst_err", errCount, 0);

    // Basic packet with an always-ready consumer.
    wordReady = 1'b1;
    sendPacket(32'h12345678);
    @(negedge clk);
    checkOutput("basic_valid", wordValid, 1);
    checkOutput("basic_word", wordOut, 32'h12345678);
    checkOutput("basic_ready_low", readyIn, 0);
    @(negedge clk);
    checkOutput("basic_valid_drop", wordValid, 0);
    checkOutput("basic_ready_back", readyIn, 1);
    checkOutput("basic_pkt", pktCount, 1);
    checkOutput("basic_word_kept", wordOut, 32'h12345678);

    // Backpressure, with the next packet's first byte offered during the stall.
    doReset();
    wordReady = 1'b0;
    sendPacket(32'h12345678);
    @(negedge clk);
    dataIn  = 8'h9A;
    endIn   = 1'b0;
    validIn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid_held", wordValid, 1);
      checkOutput("bp_word_held", wordOut, 32'h12345678);
      checkOutput("bp_ready_low", readyIn, 0);
      @(negedge clk);
    end
    wordReady = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_valid", wordValid, 0);
    checkOutput("bp_release_ready", readyIn, 1);
    checkOutput("bp_pkt", pktCount, 1);
    @(posedge clk);
    #1;
    validIn = 1'b0;
    applyStimulus(8'hBC, 1'b0);
    applyStimulus(8'hDE, 1'b0);
    applyStimulus(8'hF0, 1'b1);
    @(negedge clk);
    checkOutput("bp_second_valid", wordValid, 1);
    checkOutput("bp_second_word", wordOut, 32'h9ABCDEF0);
    @(negedge clk);
    checkOutput("bp_second_pkt", pktCount, 2);

    // Short packet followed by a good one.
    doReset();
    applyStimulus(8'hAA, 1'b0);
    applyStimulus(8'hBB, 1'b1);
    @(negedge clk);
    checkOutput("short_lenerr", lenErr, 1);
    checkOutput("short_no_valid", wordValid, 0);
    checkOutput("short_err", errCount, 1);
    @(negedge clk);
    checkOutput("short_lenerr_pulse", lenErr, 0);
    sendPacket(32'h00000100);
    @(negedge clk);
    checkOutput("short_next_word", wordOut, 32'h00000100);
    checkOutput("short_next_valid", wordValid, 1);
    @(negedge clk);
    checkOutput("short_next_pkt", pktCount, 1);
    checkOutput("short_next_err", errCount, 1);

    // Long packet, then a good one.
    doReset();
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(8'(i), 1'b0);
      checkOutput("long_no_valid", wordValid, 0);
      checkOutput("long_no_lenerr", lenErr, 0);
    end
    applyStimulus(8'h06, 1'b1);
    @(negedge clk);
    checkOutput("long_lenerr", lenErr, 1);
    checkOutput("long_valid", wordValid, 0);
    checkOutput("long_err", errCount, 1);
    checkOutput("long_pkt", pktCount, 0);
    @(negedge clk);
    checkOutput("long_lenerr_pulse", lenErr, 0);
    sendPacket(32'hDEADBEEF);
    @(negedge clk);
    checkOutput("long_next_word", wordOut, 32'hDEADBEEF);
    checkOutput("long_next_valid", wordValid, 1);
    @(negedge clk);
    checkOutput("long_next_pkt", pktCount, 1);

    // Reset in the middle of a packet.
    doReset();
    applyStimulus(8'h11, 1'b0);
    applyStimulus(8'h22, 1'b0);
    doReset();
    checkOutput("midrst_ready", readyIn, 1);
    sendPacket(32'hCAFEF00D);
    @(negedge clk);
    checkOutput("midrst_word", wordOut, 32'hCAFEF00D);
    @(negedge clk);
    checkOutput("midrst_pkt", pktCount, 1);
    checkOutput("midrst_err", errCount, 0);

    // Random gaps and consumer stalls against an in-order scoreboard.
    doReset();
    got = 0;
    fork
      begin
        for (int p = 0; p < 200; p++) begin
          w = $urandom;
          expQ.push_back(w);
          for (int b = 3; b >= 0; b--) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            applyStimulus(w[8*b +: 8], b == 0);
          end
        end
      end
      begin
        budget = 0;
        while (got < 200 && budget < 20000) begin
          @(negedge clk);
          budget++;
          wordReady = ($urandom_range(0, 3) != 0);
          if (wordValid && wordReady) begin
            if (expQ.size() == 0) begin
              checkOutput("rand_unexpected_word", wordOut, 64'hFFFFFFFFFFFFFFFF);
            end else begin
              exp = expQ.pop_front();
              checkOutput("rand_word", wordOut, exp);
            end
            got++;
          end
        end
        if (got < 200) checkOutput("rand_timeout", got, 200);
      end
    join
    wordReady = 1'b1;
    @(negedge clk);
    checkOutput("rand_pkt", pktCount, 200);
    checkOutput("rand_err", errCount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avst_word_rx.md
# avst_word_rx

Avalon-ST byte-packet receiver that reassembles fixed-length result packets, such as the 4-byte MSB-first sum packets produced by the stream adder, into one parallel word. It sits on the consumer side of a byte-wide valid/ready/end stream. It presents each complete word on a valid/ready output, applies backpressure while a word is held, and detects and counts malformed (short or long) packets.

## Interface

Parameters:
- WORD_BYTES, 4, bytes per packet/word; legal range 2..8; word width W = 8*WORD_BYTES

Ports:
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- data_in  input  8  stream byte; first byte is the most significant
- end_in  input  1  marks last byte of packet; qualified by valid_in
- valid_in  input  1  upstream byte valid
- ready_in  output  1  registered; receiver can accept a byte
- word_out  output  W  assembled word; stable while word_valid=1
- word_valid  output  1  word_out valid
- word_ready  input  1  downstream accepts word
- len_err  output  1  one-cycle pulse on a malformed packet
- pkt_count  output  16  good words delivered; saturates at 0xFFFF
- err_count  output  16  malformed packets; saturates at 0xFFFF

## Operation

- A beat is accepted when valid_in && ready_in at a rising edge. No other input state affects stream intake.
- Byte index cnt runs 0..WORD_BYTES-1. Each accepted beat shifts the accumulator: acc <= {acc[W-9:0], data_in}.
- States:
  - COLLECT (reset state)
    - Beat with end_in=1 and cnt==WORD_BYTES-1: word_out <= {acc[W-9:0], data_in}; word_valid <= 1; ready_in <= 0; cnt <= 0; go to HOLD.
    - Beat with end_in=1 and cnt<WORD_BYTES-1 (short packet): discard; len_err pulse; err_count += 1; cnt <= 0; stay in COLLECT.
    - Beat with end_in=0 and cnt==WORD_BYTES-1 (long packet): go to DRAIN; cnt <= 0.
    - Otherwise: cnt += 1.
  - DRAIN
    - ready_in stays 1; accepted beats are discarded.
    - Beat with end_in=1: len_err pulse; err_count += 1; go to COLLECT.
  - HOLD
    - ready_in=0; word_out and word_valid are held.
    - When word_ready=1: word_valid <= 0; ready_in <= 1; pkt_count += 1; go to COLLECT.
- A single-byte packet (end_in on the first beat) is a short-packet error.
- Counters saturate and do not wrap: 0xFFFF + 1 = 0xFFFF.
- word_out keeps its last value after the handshake. Consumers use it only when word_valid=1.

## Timing

- Reset values: ready_in=1, word_valid=0, word_out=0, len_err=0, pkt_count=0, err_count=0; state=COLLECT, cnt=0, acc=0.
- Reset asserted mid-packet or in HOLD discards the partial packet or held word; no error is counted.
- Word latency: the last byte is accepted at edge N. word_valid=1 and ready_in=0 are visible after edge N.
- Release: word handshake at edge M. word_valid=0 and ready_in=1 are visible after edge M. The earliest next-packet byte is accepted at edge M+1.
- Peak throughput is one word per WORD_BYTES+1 cycles.
- ready_in is driven only from registers; there is no combinational path from word_ready to ready_in.
- len_err goes high for exactly the one cycle after the edge that accepts the offending end beat.
- valid_in with ready_in=0 is ignored; upstream must hold data per Avalon-ST.
- Gaps (valid_in=0) between beats are legal anywhere and do not reset cnt.

## Test plan

- Basic: after reset, send 4 beats 0x12,0x34,0x56,0x78 with end on the 4th, word_ready=1 -> word_out=0x12345678 and word_valid=1 for one cycle, starting after the 4th beat's edge; pkt_count=1; ready_in low for exactly one cycle.
- Backpressure: same packet with word_ready=0 for 5 cycles -> word_valid and word_out stay at 0x12345678, ready_in stays 0; a second packet offered meanwhile is not accepted until the cycle after word_ready=1.
- Short packet: 0xAA,0xBB with end on 2nd beat, then 0x00,0x00,0x01,0x00 with end -> one len_err pulse, err_count=1, then word_out=0x00000100, pkt_count=1.
- Long packet: 6 beats 0x01..0x06 with end on the 6th -> no word_valid, one len_err pulse after the 6th beat, err_count=1; the next good packet 0xDEADBEEF is delivered correctly.
- Random gaps: 200 random good packets with random valid_in gaps and random word_ready stalls -> scoreboard matches all words in order, pkt_count=200, err_count=0.
- Reset mid-packet: 2 bytes accepted, then reset for 1 cycle, then a full packet 0xCAFEF00D -> word_out=0xCAFEF00D, err_count=0, pkt_count=1.
